pixel_frame_assembler: RTL and testbench

- Upstream stage of the digit classifier. It takes a serial grayscale pixel stream and binarizes each pixel against a programmable threshold.
- It assembles one 12x12 frame into the 144-bit feature vector that the MLP/DTC/RFC model consumes.
- It drives the model's predict enable and replaces the fixed pattern selector as the feature source.
- A valid/ready handshake on both sides lets a new frame fill while the previous one is held.

---
 rtl/pixel_frame_assembler.sv | 124 ++++++++++++
 tb/tb_pixel_frame_assembler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_assembler.sv
// Binarizes a serial grayscale pixel stream and assembles 12x12 frames into a 144-bit feature vector.
// Optional build macro MIN_INK_EN rejects frames whose ink count is below MIN_INK.
module pixel_frame_assembler #(
  parameter int FRAME_BITS = 144,
  parameter int MIN_INK    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [7:0]            pix_data,
  input  logic                  pix_sof,
  input  logic [7:0]            threshold,
  output logic [FRAME_BITS-1:0] feature,
  output logic                  feat_valid,
  input  logic                  feat_ready,
  output logic                  predict,
  output logic [7:0]            ink_count,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

`ifdef MIN_INK_EN
  localparam bit MinInkOn = 1'b1;
`else
  localparam bit MinInkOn = 1'b0;
`endif

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [FRAME_BITS-1:0]   asm_q;
  logic [7:0]              ink_run_q;
  logic [FRAME_BITS-1:0]   feature_q;
  logic [7:0]              ink_count_q;
  logic                    feat_valid_q;
  logic                    predict_q;
  logic                    frame_err_q;

  logic                    accept;
  logic                    pix_bit;
  logic [CNT_W-1:0]        idx_d;
  logic [FRAME_BITS-1:0]   asm_d;
  logic [7:0]              ink_d;
  logic                    reject;

  // Only the last beat of a frame can stall, and only while the previous frame is still unacknowledged.
  assign pix_ready = !((state_q == FILL) && (cnt_q == LAST) && feat_valid_q && !feat_ready);
  assign accept    = pix_valid && pix_ready;
  assign pix_bit   = (pix_data >= threshold);

  always_comb begin
    idx_d = pix_sof ? LAST : (LAST - cnt_q);
    asm_d = pix_sof ? '0 : asm_q;
    asm_d[idx_d] = pix_bit;
    ink_d = pix_sof ? {7'd0, pix_bit} : (ink_run_q + {7'd0, pix_bit});
    reject = MinInkOn && (ink_d < 8'(MIN_INK));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      asm_q        <= '0;
      ink_run_q    <= '0;
      feature_q    <= '0;
      ink_count_q  <= '0;
      feat_valid_q <= 1'b0;
      predict_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (feat_valid_q && feat_ready) feat_valid_q <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (pix_sof) begin
              asm_q     <= asm_d;
              ink_run_q <= ink_d;
              cnt_q     <= CNT_W'(1);
              state_q   <= FILL;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          FILL: begin
            if (pix_sof) begin
              asm_q       <= asm_d;
              ink_run_q   <= ink_d;
              cnt_q       <= CNT_W'(1);
              frame_err_q <= 1'b1;
            end else if (cnt_q != LAST) begin
              asm_q     <= asm_d;
              ink_run_q <= ink_d;
              cnt_q     <= cnt_q + CNT_W'(1);
            end else begin
              // Last pixel: publish directly from the next-state assembly so bit 0 is included.
              state_q <= IDLE;
              cnt_q   <= '0;
              if (reject) begin
                frame_err_q <= 1'b1;
              end else begin
                feature_q    <= asm_d;
                ink_count_q  <= ink_d;
                feat_valid_q <= 1'b1;
                predict_q    <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign feature    = feature_q;
  assign ink_count  = ink_count_q;
  assign feat_valid = feat_valid_q;
  assign predict    = predict_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_pixel_frame_assembler.sv
// Scoreboard bench for pixel_frame_assembler: directed frames, monitor pops expected frames on each publish.
module tb_pixel_frame_assembler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         pix_valid;
  logic         pix_ready;
  logic [7:0]   pix_data;
  logic         pix_sof;
  logic [7:0]   threshold;
  logic [143:0] feature;
  logic         feat_valid;
  logic         feat_ready;
  logic         predict;
  logic [7:0]   ink_count;
  logic         frame_err;

  always #5 clk = ~clk;

  pixel_frame_assembler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .threshold  (threshold),
    .feature    (feature),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .predict    (predict),
    .ink_count  (ink_count),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [143:0] f;
    logic [7:0]   ink;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pix_arr[144];
  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;
  int         pub_seen = 0;
  int         pub_exp = 0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] thr);
    exp_t e;
    e.f = '0;
    e.ink = 8'd0;
    for (int k = 0; k < 144; k++) begin
      if (pix_arr[k] >= thr) begin
        e.f[143-k] = 1'b1;
        e.ink = e.ink + 8'd1;
      end
    end
    return e;
  endfunction

  task automatic push_exp();
    sb.push_back(model(threshold));
    pub_exp++;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was accepted.
  task automatic beat(input logic [7:0] d, input logic s);
    int n = 0;
    pix_data = d;
    pix_sof = s;
    pix_valid = 1'b1;
    #1;
    while (!pix_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!pix_ready) chk("beat_accept_timeout", 144'(pix_ready), 144'(1));
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) beat(pix_arr[k], k == 0);
  endtask

  task automatic ack();
    feat_ready = 1'b1;
    @(negedge clk);
    feat_ready = 1'b0;
  endtask

  // Monitor: a new frame is presented when feat_valid rises or stays high right after a handshake.
  initial begin
    logic prev_fv;
    logic prev_hs;
    exp_t e;
    prev_fv = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_fv = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (feat_valid && (!prev_fv || prev_hs)) begin
          pub_seen++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_publish actual=%0h required=none", feature);
          end else begin
            e = sb.pop_front();
            chk("sb_feature", feature, e.f);
            chk("sb_ink", 144'(ink_count), 144'(e.ink));
            chk("sb_predict", 144'(predict), 144'(1));
          end
        end
        prev_fv = feat_valid;
        prev_hs = feat_valid && feat_ready;
      end
      err_seen += int'(frame_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t ea;
    exp_t eb;
    int   e0;
    reset_n = 1'b0;
    pix_valid = 1'b0;
    pix_data = 8'd0;
    pix_sof = 1'b0;
    threshold = 8'h80;
    feat_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_feature", feature, 144'd0);
    chk("rst_feat_valid", 144'(feat_valid), 144'(0));
    chk("rst_predict", 144'(predict), 144'(0));
    chk("rst_ink", 144'(ink_count), 144'(0));
    chk("rst_frame_err", 144'(frame_err), 144'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_pix_ready", 144'(pix_ready), 144'(1));
    @(negedge clk);

    // Frame A: first row ink
    threshold = 8'h80;
    for (int k = 0; k < 144; k++) pix_arr[k] = (k < 12) ? 8'hFF : 8'h00;
    push_exp();
    send_range(0, 143);
    #1;
    chk("a_top_row", 144'(feature[143:132]), 144'(12'hFFF));
    chk("a_rest_zero", 144'(feature[131:0]), 144'd0);
    chk("a_ink", 144'(ink_count), 144'(12));
    chk("a_valid", 144'(feat_valid), 144'(1));
    chk("a_predict", 144'(predict), 144'(1));
    @(negedge clk);
    ack();
    #1;
    chk("a_ack_clears", 144'(feat_valid), 144'(0));
    @(negedge clk);

    // Threshold boundary: equality binarizes to 1
    threshold = 8'h40;
    for (int k = 0; k < 144; k++) pix_arr[k] = 8'h00;
    pix_arr[0] = 8'h40;
    pix_arr[1] = 8'h3F;
    push_exp();
    send_range(0, 143);
    #1;
    chk("thr_bit143", 144'(feature[143]), 144'(1));
    chk("thr_bit142", 144'(feature[142]), 144'(0));
    chk("thr_ink", 144'(ink_count), 144'(1));
    @(negedge clk);
    ack();
    @(negedge clk);

    // SOF restart at beat 50
    threshold = 8'h80;
    e0 = err_seen;
    for (int k = 0; k < 144; k++) pix_arr[k] = 8'hFF;
    send_range(0, 49);
    for (int k = 0; k < 144; k++) pix_arr[k] = (k % 3 == 0) ? 8'hC0 : 8'h10;
    push_exp();
    send_range(0, 143);
    repeat (2) @(negedge clk);
    chk("restart_err_pulses", 144'(err_seen - e0), 144'(1));
    chk("restart_ink", 144'(ink_count), 144'(48));
    e0 = err_seen;
    beat(8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    chk("idle_drop_err", 144'(err_seen - e0), 144'(1));
    chk("idle_drop_ink", 144'(ink_count), 144'(48));
    ack();
    @(negedge clk);

    // Back-pressure: hold frame A2, stream B
    for (int k = 0; k < 144; k++) pix_arr[k] = (k < 72) ? 8'h90 : 8'h20;
    ea = model(threshold);
    push_exp();
    send_range(0, 143);
    for (int k = 0; k < 144; k++) pix_arr[k] = (k >= 132) ? 8'hFF : 8'h00;
    eb = model(threshold);
    push_exp();
    send_range(0, 142);
    pix_data = pix_arr[143];
    pix_sof = 1'b0;
    pix_valid = 1'b1;
    #1;
    chk("bp_ready_low", 144'(pix_ready), 144'(0));
    chk("bp_hold_feature", feature, ea.f);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_still_low", 144'(pix_ready), 144'(0));
    chk("bp_ink_held", 144'(ink_count), 144'(72));
    @(negedge clk);
    feat_ready = 1'b1;
    #1;
    chk("bp_ready_high", 144'(pix_ready), 144'(1));
    @(negedge clk);
    feat_ready = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("bp_feature_b", feature, eb.f);
    chk("bp_valid_b", 144'(feat_valid), 144'(1));
    chk("bp_ink_b", 144'(ink_count), 144'(12));
    @(negedge clk);
    ack();
    @(negedge clk);

    // Mid-frame reset, then 5-ink frame
    for (int k = 0; k < 144; k++) pix_arr[k] = 8'h05;
    pix_arr[0] = 8'hAA;
    pix_arr[20] = 8'hAA;
    pix_arr[70] = 8'hAA;
    pix_arr[100] = 8'hAA;
    pix_arr[143] = 8'hAA;
    send_range(0, 99);
    reset_n = 1'b0;
    #1;
    chk("mrst_feature", feature, 144'd0);
    chk("mrst_valid", 144'(feat_valid), 144'(0));
    chk("mrst_predict", 144'(predict), 144'(0));
    chk("mrst_ink", 144'(ink_count), 144'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mrst_ready", 144'(pix_ready), 144'(1));
    @(negedge clk);
    e0 = err_seen;
    beat(8'h11, 1'b0);
    beat(8'h12, 1'b0);
    repeat (2) @(negedge clk);
    chk("mrst_drop_err", 144'(err_seen - e0), 144'(2));
    e0 = err_seen;
`ifndef MIN_INK_EN
    push_exp();
`endif
    send_range(0, 143);
    repeat (2) @(negedge clk);
    #1;
`ifdef MIN_INK_EN
    chk("lowink_err", 144'(err_seen - e0), 144'(1));
    chk("lowink_valid", 144'(feat_valid), 144'(0));
    chk("lowink_predict", 144'(predict), 144'(0));
`else
    chk("lowink_err", 144'(err_seen - e0), 144'(0));
    chk("lowink_valid", 144'(feat_valid), 144'(1));
    chk("lowink_ink", 144'(ink_count), 144'(5));
`endif
    repeat (4) @(negedge clk);
    chk("publish_count", 144'(pub_seen), 144'(pub_exp));
    chk("sb_drained", 144'(sb.size()), 144'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
